wf_rr_select_arbiter: RTL and testbench

- Round-robin arbiter that shares one 40-to-1 wavefront datapath mux among 40 wavefront slots.
- Produces the 6-bit mux select plus a valid/ready grant to the downstream consumer.
- Tracks which wavefronts are in flight, so a slot cannot win again until the downstream releases it.
- Sits between the per-wavefront ready flags and the issue/fetch datapath that consumes the selected wavefront's fields.

---
 rtl/wf_rr_select_arbiter.sv | 93 +++++++++
 tb/tb_wf_rr_select_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wf_rr_select_arbiter.sv
// Round-robin arbiter sharing one 40-to-1 wavefront datapath mux among the slots.
// Issues a registered select and grant, and tracks in-flight slots until the downstream releases them.
module wf_rr_select_arbiter #(
   parameter int NUM_WF = 40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_WF-1:0] wf_req,
   input  logic              halt,
   input  logic              gnt_ready,
   input  logic              release_valid,
   input  logic [5:0]        release_wfid,
   output logic              gnt_valid,
   output logic [5:0]        gnt_wfid,
   output logic [NUM_WF-1:0] gnt_onehot,
   output logic [NUM_WF-1:0] busy_mask
);

   localparam logic [5:0] LAST_ID = 6'(NUM_WF - 1);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_GRANTED = 1'b1
   } state_t;

   state_t            state;
   logic [5:0]        last_wf;
   logic              accept;
   logic              load;
   logic [5:0]        base;
   logic [5:0]        start;
   logic [NUM_WF-1:0] elig;
   logic              found;
   logic [5:0]        win;
   logic [6:0]        idx;
   logic [NUM_WF-1:0] busy_next;

   assign gnt_valid = (state == S_GRANTED);
   assign accept    = gnt_valid & gnt_ready;

   // On accept the pointer moves to the accepted slot in the same edge, so search from there.
   assign base  = accept ? gnt_wfid : last_wf;
   assign start = (base == LAST_ID) ? 6'd0 : base + 6'd1;
   assign elig  = wf_req & ~busy_mask & (accept ? ~gnt_onehot : {NUM_WF{1'b1}});

   // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int i = 0; i < NUM_WF; i++) begin
         idx = {1'b0, start} + 7'(i);
         if (idx >= 7'(NUM_WF)) idx = idx - 7'(NUM_WF);
         if (!found && elig[idx[5:0]]) begin
            found = 1'b1;
            win   = idx[5:0];
         end
      end
   end

   assign load = !halt && found && ((state == S_IDLE) || accept);

   // The accept set is applied after the release clear, so a same-id collision stays busy.
   always_comb begin
      busy_next = busy_mask;
      if (release_valid && (release_wfid < 6'(NUM_WF))) busy_next[release_wfid] = 1'b0;
      if (accept) busy_next[gnt_wfid] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         gnt_wfid   <= '0;
         gnt_onehot <= '0;
         busy_mask  <= '0;
         last_wf    <= LAST_ID;
      end else begin
         busy_mask <= busy_next;
         if (accept) last_wf <= gnt_wfid;
         if (load) begin
            state      <= S_GRANTED;
            gnt_wfid   <= win;
            gnt_onehot <= {{(NUM_WF-1){1'b0}}, 1'b1} << win;
         end else if (accept || (state == S_IDLE)) begin
            state      <= S_IDLE;
            gnt_wfid   <= '0;
            gnt_onehot <= '0;
         end
      end
   end

endmodule

// File: tb/tb_wf_rr_select_arbiter.sv
// Self-checking bench for wf_rr_select_arbiter: table-driven vectors fed through an expected-value scoreboard.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_wf_rr_select_arbiter;

   localparam int NW = 40;

   typedef struct {
      logic [NW-1:0] req;
      logic          halt;
      logic          ready;
      logic          rel_v;
      logic [5:0]    rel_id;
      logic          exp_valid;
      logic [5:0]    exp_wfid;
      logic [NW-1:0] exp_busy;
   } vec_t;

   typedef struct {
      string         tag;
      logic          valid;
      logic [5:0]    wfid;
      logic [NW-1:0] busy;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [NW-1:0] wf_req;
   logic          halt;
   logic          gnt_ready;
   logic          release_valid;
   logic [5:0]    release_wfid;
   logic          gnt_valid;
   logic [5:0]    gnt_wfid;
   logic [NW-1:0] gnt_onehot;
   logic [NW-1:0] busy_mask;

   int   n_total = 0;
   int   n_pass  = 0;
   exp_t sb[$];

   wf_rr_select_arbiter #(.NUM_WF(NW)) dut (
      .clk           (clk),
      .rst           (rst),
      .wf_req        (wf_req),
      .halt          (halt),
      .gnt_ready     (gnt_ready),
      .release_valid (release_valid),
      .release_wfid  (release_wfid),
      .gnt_valid     (gnt_valid),
      .gnt_wfid      (gnt_wfid),
      .gnt_onehot    (gnt_onehot),
      .busy_mask     (busy_mask)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [NW-1:0] bit_of(input int i);
      return {{(NW-1){1'b0}}, 1'b1} << i;
   endfunction

   function automatic vec_t mk(input logic [NW-1:0] req, input logic hlt, input logic rdy,
                               input logic rv, input logic [5:0] rid,
                               input logic ev, input logic [5:0] ew, input logic [NW-1:0] eb);
      vec_t v;
      v.req = req; v.halt = hlt; v.ready = rdy; v.rel_v = rv; v.rel_id = rid;
      v.exp_valid = ev; v.exp_wfid = ew; v.exp_busy = eb;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of stimulus, queue its expectation, then compare once the edge has produced output.
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      exp_t got;
      wf_req        = v.req;
      halt          = v.halt;
      gnt_ready     = v.ready;
      release_valid = v.rel_v;
      release_wfid  = v.rel_id;
      e.tag = tag; e.valid = v.exp_valid; e.wfid = v.exp_wfid; e.busy = v.exp_busy;
      sb.push_back(e);
      step();
      if (sb.size() == 0) begin
         check({tag, ".sb_empty"}, 64'd0, 64'd1);
      end else begin
         got = sb.pop_front();
         check({got.tag, ".valid"}, 64'(gnt_valid), 64'(got.valid));
         if (got.valid) check({got.tag, ".wfid"}, 64'(gnt_wfid), 64'(got.wfid));
         check({got.tag, ".onehot"}, 64'(gnt_onehot), got.valid ? 64'(bit_of(int'(got.wfid))) : 64'd0);
         check({got.tag, ".busy"}, 64'(busy_mask), 64'(got.busy));
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".valid"},  64'(gnt_valid),  64'd0);
      check({tag, ".wfid"},   64'(gnt_wfid),   64'd0);
      check({tag, ".onehot"}, 64'(gnt_onehot), 64'd0);
      check({tag, ".busy"},   64'(busy_mask),  64'd0);
   endtask

   task automatic do_reset(input string tag);
      wf_req = '0; halt = 1'b0; gnt_ready = 1'b0; release_valid = 1'b0; release_wfid = '0;
      #2;
      rst = 1'b0;
      #3;
      check_zero(tag);
      @(negedge clk);
      rst = 1'b1;
   endtask

   localparam logic [NW-1:0] ALL   = {NW{1'b1}};
   localparam logic [NW-1:0] NONE  = '0;

   vec_t t2[$];
   vec_t t3[$];
   vec_t t4[$];
   vec_t t5[$];

   initial begin
      logic [NW-1:0] r2;
      logic [NW-1:0] r5;
      rst = 1'b1;
      r2 = bit_of(5) | bit_of(17) | bit_of(39);
      r5 = bit_of(1) | bit_of(2);

      // Round-robin over slots 5/17/39 with each id released the cycle after its accept.
      t2.push_back(mk(r2,   0, 1, 0, 0,  1, 5,  NONE));
      t2.push_back(mk(r2,   0, 1, 0, 0,  1, 17, bit_of(5)));
      t2.push_back(mk(r2,   0, 1, 1, 5,  1, 39, bit_of(17)));
      t2.push_back(mk(r2,   0, 1, 1, 17, 1, 5,  bit_of(39)));
      t2.push_back(mk(r2,   0, 1, 1, 39, 1, 17, bit_of(5)));
      t2.push_back(mk(r2,   0, 1, 1, 5,  1, 39, bit_of(17)));
      t2.push_back(mk(r2,   0, 1, 1, 17, 1, 5,  bit_of(39)));
      t2.push_back(mk(NONE, 0, 1, 1, 39, 0, 0,  bit_of(5)));
      t2.push_back(mk(NONE, 0, 0, 1, 5,  0, 0,  NONE));

      // Grant held under backpressure while the request drops away.
      t3.push_back(mk(bit_of(3), 0, 0, 0, 0, 1, 3, NONE));
      t3.push_back(mk(bit_of(3), 0, 0, 0, 0, 1, 3, NONE));
      t3.push_back(mk(NONE,      0, 0, 0, 0, 1, 3, NONE));
      t3.push_back(mk(NONE,      0, 0, 0, 0, 1, 3, NONE));
      t3.push_back(mk(NONE,      0, 1, 0, 0, 0, 0, bit_of(3)));
      t3.push_back(mk(NONE,      0, 0, 1, 3, 0, 0, NONE));

      // Same-edge accept+release of slot 10, release latency, and out-of-range release.
      t4.push_back(mk(bit_of(10), 0, 0, 0, 0,  1, 10, NONE));
      t4.push_back(mk(bit_of(10), 0, 1, 1, 10, 0, 0,  bit_of(10)));
      t4.push_back(mk(bit_of(10), 0, 0, 0, 0,  0, 0,  bit_of(10)));
      t4.push_back(mk(bit_of(10), 0, 0, 1, 10, 0, 0,  NONE));
      t4.push_back(mk(bit_of(10), 0, 0, 0, 0,  1, 10, NONE));
      t4.push_back(mk(NONE,       0, 1, 0, 0,  0, 0,  bit_of(10)));
      t4.push_back(mk(NONE,       0, 0, 1, 42, 0, 0,  bit_of(10)));
      t4.push_back(mk(NONE,       0, 0, 1, 10, 0, 0,  NONE));

      // halt blocks loads from idle, lets an accept complete, then releases the next grant.
      t5.push_back(mk(r5, 1, 0, 0, 0, 0, 0, NONE));
      t5.push_back(mk(r5, 1, 0, 0, 0, 0, 0, NONE));
      t5.push_back(mk(r5, 0, 0, 0, 0, 1, 1, NONE));
      t5.push_back(mk(r5, 1, 0, 0, 0, 1, 1, NONE));
      t5.push_back(mk(r5, 1, 1, 0, 0, 0, 0, bit_of(1)));
      t5.push_back(mk(r5, 0, 0, 0, 0, 1, 2, bit_of(1)));
      t5.push_back(mk(r5, 0, 0, 1, 1, 1, 2, NONE));

      // Full sweep: all slots requesting, always ready -> 0..39 back to back, then idle.
      do_reset("rst1");
      for (int k = 0; k < NW; k++)
         apply(mk(ALL, 0, 1, 0, 0, 1, 6'(k), bit_of(k) - 40'd1), $sformatf("sweep%0d", k));
      apply(mk(ALL, 0, 1, 0, 0, 0, 0, ALL), "sweep_end");
      apply(mk(ALL, 0, 1, 0, 0, 0, 0, ALL), "sweep_idle");

      do_reset("rst2");
      foreach (t2[i]) apply(t2[i], $sformatf("rr%0d", i));
      do_reset("rst3");
      foreach (t3[i]) apply(t3[i], $sformatf("hold%0d", i));
      do_reset("rst4");
      foreach (t4[i]) apply(t4[i], $sformatf("rel%0d", i));
      do_reset("rst5");
      foreach (t5[i]) apply(t5[i], $sformatf("halt%0d", i));

      // Asynchronous reset in mid-cycle while a grant is outstanding.
      do_reset("rst6");
      apply(mk(ALL, 0, 0, 0, 0, 1, 0, NONE), "async_pre0");
      apply(mk(ALL, 0, 1, 0, 0, 1, 1, bit_of(0)), "async_pre1");
      apply(mk(ALL, 0, 0, 0, 0, 1, 1, bit_of(0)), "async_pre2");
      #3;
      rst = 1'b0;
      #1;
      check_zero("async_mid");
      #1;
      rst = 1'b1;
      apply(mk(ALL, 0, 0, 0, 0, 1, 0, NONE), "async_post");
      apply(mk(ALL, 0, 1, 0, 0, 1, 1, bit_of(0)), "async_post1");

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
